// File: rtl/axi_ar_stream_gen_pkg.sv
// axi_ar_stream_gen_pkg: shared state, error-bit and mode definitions for the AR stream generator.
package axi_ar_stream_gen_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;
  localparam int ERR_BAD_ID = 0;
  localparam int ERR_NO_OUTST = 1;
  localparam int ERR_BEATS = 2;
  localparam logic MODE_STRIDE = 1'b0;
  localparam logic MODE_TRACE = 1'b1;
endpackage

// File: rtl/ar_stream_ts_fifo.sv
// ar_stream_ts_fifo: small synchronous show-ahead FIFO holding AR handshake timestamps.
module ar_stream_ts_fifo #(
  parameter int WIDTH = 16,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] wr, rd;
  logic empty, full;
  assign empty = wr == rd;
  assign full = (wr ^ rd) == {1'b1, {LOG_DEPTH{1'b0}}};
  assign dout = mem[rd[LOG_DEPTH-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wr[LOG_DEPTH-1:0]] <= din;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr <= '0;
      rd <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/axi_ar_stream_gen.sv
// axi_ar_stream_gen: AXI AR burst generator (stride or trace RAM source) with outstanding cap, gap and R checking.
// Define AXI_AR_STREAM_GEN_LAT_STATS_EN to add latMin/latMax handshake-to-r_last latency outputs.
module axi_ar_stream_gen
  import axi_ar_stream_gen_pkg::*;
#(
  parameter int ADDR_BITS           = 16,
  parameter int TID_WIDTH           = 8,
  parameter int BURST_LEN_WIDTH     = 8,
  parameter int LOG_TRACE_DEPTH     = 6,
  parameter int LOG_MAX_OUTSTANDING = 3,
  parameter int CNT_WIDTH           = 16,
  parameter int GAP_WIDTH           = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [LOG_TRACE_DEPTH-1:0]   ld_idx,
  input  logic [ADDR_BITS-1:0]         ld_addr,
  input  logic                         start,
  input  logic                         cfg_mode,
  input  logic [ADDR_BITS-1:0]         cfg_base,
  input  logic [ADDR_BITS-1:0]         cfg_stride,
  input  logic [CNT_WIDTH-1:0]         cfg_count,
  input  logic [BURST_LEN_WIDTH-1:0]   cfg_len,
  input  logic [TID_WIDTH-1:0]         cfg_id,
  input  logic [GAP_WIDTH-1:0]         cfg_gap,
  input  logic [LOG_MAX_OUTSTANDING:0] cfg_outLimit,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [ADDR_BITS-1:0]         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
  output logic [TID_WIDTH-1:0]         m_ar_id,
  input  logic                         m_r_valid,
  output logic                         m_r_ready,
  input  logic                         m_r_last,
  input  logic [TID_WIDTH-1:0]         m_r_id,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         reqCnt,
  output logic [CNT_WIDTH-1:0]         respCnt,
  output logic [2:0]                   errorCode
`ifdef AXI_AR_STREAM_GEN_LAT_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]         latMin,
  output logic [CNT_WIDTH-1:0]         latMax
`endif
);
  localparam int MAX_OUT = 1 << LOG_MAX_OUTSTANDING;
  localparam int OW = LOG_MAX_OUTSTANDING + 1;
  state_t state, state_nx;
  logic rdy, mode_q, go, hs, rbeat, rlast, dec;
  logic [ADDR_BITS-1:0] ram [2**LOG_TRACE_DEPTH];
  logic [ADDR_BITS-1:0] stride_q;
  logic [CNT_WIDTH-1:0] count_q, req_nx;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [OW-1:0] lim_q, lim_in, outst;
  logic [LOG_TRACE_DEPTH-1:0] idx;
  logic [BURST_LEN_WIDTH:0] beats, beats_nx, len_p1;
  logic [2:0] err_new;
  assign go = start && state == IDLE;
  assign hs = m_ar_valid && m_ar_ready;
  assign rbeat = m_r_valid && m_r_ready;
  assign rlast = rbeat && m_r_last;
  assign dec = rlast && outst != '0;
  assign req_nx = reqCnt + 1'b1;
  assign beats_nx = beats + 1'b1;
  assign len_p1 = {1'b0, m_ar_len} + 1'b1;
  assign lim_in = (cfg_outLimit == '0) ? OW'(1) :
                  (cfg_outLimit > OW'(MAX_OUT)) ? OW'(MAX_OUT) : cfg_outLimit;
  // Purely state-decoded so that an asynchronous reset drops valid immediately.
  assign m_ar_valid = state == ISSUE && outst < lim_q;
  assign m_r_ready = rdy;
  assign ld_ready = rdy && state == IDLE;
  assign busy = state inside {ISSUE, GAP, DRAIN};
  assign done = state == DONE;
  always_comb begin
    err_new = '0;
    err_new[ERR_BAD_ID] = rbeat && m_r_id != m_ar_id;
    err_new[ERR_NO_OUTST] = rlast && outst == '0;
    err_new[ERR_BEATS] = rlast && beats_nx != len_p1;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (cfg_count == '0) ? DONE : ISSUE;
      ISSUE: if (hs) state_nx = (req_nx == count_q) ? DRAIN : (gap_q != '0) ? GAP : ISSUE;
      GAP:   if (gap_cnt == GAP_WIDTH'(1)) state_nx = ISSUE;
      DRAIN: if (outst == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (ld_valid && ld_ready) ram[ld_idx] <= ld_addr;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      mode_q    <= MODE_STRIDE;
      stride_q  <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      lim_q     <= '0;
      outst     <= '0;
      idx       <= '0;
      beats     <= '0;
      m_ar_addr <= '0;
      m_ar_len  <= '0;
      m_ar_id   <= '0;
      reqCnt    <= '0;
      respCnt   <= '0;
      errorCode <= '0;
    end else begin
      state <= state_nx;
      rdy   <= 1'b1;
      // Trace mode prefetches the next RAM word on every handshake, so ISSUE never stalls for the read.
      if (go) begin
        mode_q    <= cfg_mode;
        stride_q  <= cfg_stride;
        count_q   <= cfg_count;
        gap_q     <= cfg_gap;
        lim_q     <= lim_in;
        m_ar_len  <= cfg_len;
        m_ar_id   <= cfg_id;
        m_ar_addr <= (cfg_mode == MODE_TRACE) ? ram[0] : cfg_base;
        idx       <= LOG_TRACE_DEPTH'(1);
        reqCnt    <= '0;
      end else if (hs) begin
        m_ar_addr <= (mode_q == MODE_TRACE) ? ram[idx] : m_ar_addr + stride_q;
        idx       <= idx + 1'b1;
        reqCnt    <= req_nx;
        gap_cnt   <= gap_q;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      outst     <= outst + OW'(hs) - OW'(dec);
      beats     <= rlast ? '0 : rbeat ? beats_nx : beats;
      respCnt   <= go ? '0 : respCnt + CNT_WIDTH'(rlast);
      errorCode <= go ? '0 : errorCode | err_new;
    end
  end
`ifdef AXI_AR_STREAM_GEN_LAT_STATS_EN
  logic [CNT_WIDTH-1:0] ts, ts_head, lat;
  assign lat = ts - ts_head;
  ar_stream_ts_fifo #(
    .WIDTH(CNT_WIDTH),
    .LOG_DEPTH(LOG_MAX_OUTSTANDING)
  ) u_ts_fifo (
    .clk,
    .resetN,
    .clr(go),
    .push(hs),
    .pop(dec),
    .din(ts),
    .dout(ts_head)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ts     <= '0;
      latMin <= '1;
      latMax <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (go) begin
        latMin <= '1;
        latMax <= '0;
      end else if (dec) begin
        if (lat < latMin) latMin <= lat;
        if (lat > latMax) latMax <= lat;
      end
    end
  end
`endif
endmodule

// File: tb/tb_axi_ar_stream_gen.sv
// tb_axi_ar_stream_gen: randomized and directed checks of axi_ar_stream_gen against an address-list / pending-burst model.
module tb_axi_ar_stream_gen;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic ld_valid = 1'b0, ld_ready;
  logic [1:0] ld_idx = '0;
  logic [15:0] ld_addr = '0;
  logic start = 1'b0, cfg_mode = 1'b0;
  logic [15:0] cfg_base = '0, cfg_stride = '0, cfg_count = '0;
  logic [7:0] cfg_len = '0, cfg_id = '0, cfg_gap = '0;
  logic [3:0] cfg_outLimit = '0;
  logic m_ar_valid, m_ar_ready = 1'b0;
  logic [15:0] m_ar_addr;
  logic [7:0] m_ar_len, m_ar_id;
  logic m_r_valid = 1'b0, m_r_ready, m_r_last = 1'b0;
  logic [7:0] m_r_id = '0;
  logic busy, done;
  logic [15:0] reqCnt, respCnt;
  logic [2:0] errorCode;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] tram [4];

  axi_ar_stream_gen #(.LOG_TRACE_DEPTH(2)) dut (
    .clk(clk), .resetN(resetN), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx),
    .ld_addr(ld_addr), .start(start), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_count(cfg_count), .cfg_len(cfg_len), .cfg_id(cfg_id),
    .cfg_gap(cfg_gap), .cfg_outLimit(cfg_outLimit), .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .busy(busy), .done(done), .reqCnt(reqCnt), .respCnt(respCnt), .errorCode(errorCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] i, input logic [15:0] a);
    ld_valid = 1'b1;
    ld_idx = i;
    ld_addr = a;
    tick();
    ld_valid = 1'b0;
    tram[i] = a;
  endtask

  task automatic start_run(input bit mode, input logic [15:0] base, stride, cnt,
                           input logic [7:0] len, id, gap, input logic [3:0] ol);
    cfg_mode = mode; cfg_base = base; cfg_stride = stride; cfg_count = cnt;
    cfg_len = len; cfg_id = id; cfg_gap = gap; cfg_outLimit = ol;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble the config inputs: the run must use the values captured at start.
    cfg_mode = 1'($urandom); cfg_base = 16'($urandom); cfg_stride = 16'($urandom);
    cfg_count = 16'($urandom); cfg_len = 8'($urandom); cfg_id = 8'($urandom);
    cfg_gap = 8'($urandom); cfg_outLimit = 4'($urandom);
  endtask

  task automatic beat(input logic [7:0] id, input bit last);
    m_r_valid = 1'b1;
    m_r_id = id;
    m_r_last = last;
    tick();
    m_r_valid = 1'b0;
    m_r_last = 1'b0;
  endtask

  task automatic burst(input logic [7:0] id, input int n);
    for (int i = 0; i < n; i++) beat(id, i == n - 1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1);
    tick();
  endtask

  task automatic run_cfg(input bit mode, input logic [15:0] base, stride, cnt,
                         input logic [7:0] len, id, gap, input logic [3:0] ol,
                         input int rdy_pct, rsp_pct);
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int lim, hs, npend, bi, t_last, cyc;
    bit fin, exact;
    e = base; hs = 0; npend = 0; bi = 0; t_last = 0; cyc = 0; fin = 1'b0;
    lim = (ol == 0) ? 1 : (ol > 8) ? 8 : int'(ol);
    exact = rdy_pct >= 100 && lim >= int'(cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back(mode ? tram[i % 4] : e);
      e = e + stride;
    end
    start_run(mode, base, stride, cnt, len, id, gap, ol);
    while (!fin && cyc < 3000) begin
      m_ar_ready = int'($urandom_range(99)) < rdy_pct;
      m_r_valid = npend > 0 && int'($urandom_range(99)) < rsp_pct;
      m_r_id = id;
      m_r_last = m_r_valid && bi == int'(len);
      @(negedge clk);
      if (cyc == 0) begin
        chk("busy_start", busy, cnt != 0);
        chk("err_clear", errorCode, 0);
      end
      if (m_ar_valid) chk("ar_limit", npend < lim, 1);
      if (m_ar_valid && m_ar_ready) begin
        chk("ar_extra", hs < int'(cnt), 1);
        if (hs < int'(cnt)) begin
          chk("ar_addr", m_ar_addr, exp_q[hs]);
          chk("ar_len", m_ar_len, len);
          chk("ar_id", m_ar_id, id);
        end
        if (hs > 0) begin
          if (exact) chk("ar_spacing", cyc - t_last, int'(gap) + 1);
          else chk("ar_gap_min", cyc - t_last >= int'(gap) + 1, 1);
        end
        t_last = cyc;
        hs++;
        npend++;
      end
      if (m_r_valid) begin
        if (m_r_last) begin
          npend--;
          bi = 0;
        end else bi++;
      end
      if (done) begin
        chk("end_reqcnt", reqCnt, cnt);
        chk("end_respcnt", respCnt, cnt);
        chk("end_err", errorCode, 0);
        chk("end_busy", busy, 0);
        chk("end_hs", hs, int'(cnt));
        fin = 1'b1;
      end
      tick();
      cyc++;
    end
    m_r_valid = 1'b0;
    m_r_last = 1'b0;
    chk("run_finished", fin, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    tick();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ar_valid", m_ar_valid, 0);
    chk("rst_r_ready", m_r_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reqcnt", reqCnt, 0);
    chk("rst_respcnt", respCnt, 0);
    chk("rst_err", errorCode, 0);
    chk("rst_addr", m_ar_addr, 0);
    chk("rst_len_id", {m_ar_len, m_ar_id}, 0);
    @(posedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    chk("r_ready_pre", m_r_ready, 0);
    tick();
    chk("r_ready_post", m_r_ready, 1);
    chk("ld_ready_idle", ld_ready, 1);

    run_cfg(1'b0, 16'h0100, 16'h0003, 16'd4, 8'd0, 8'h01, 8'd0, 4'd8, 100, 100);

    load(2'd0, 16'h0eef);
    load(2'd1, 16'h0ef2);
    load(2'd2, 16'h1000);
    load(2'd3, 16'h2345);
    run_cfg(1'b1, 16'h0000, 16'h0000, 16'd5, 8'd0, 8'h21, 8'd0, 4'd8, 100, 100);
    run_cfg(1'b1, 16'h0000, 16'h0000, 16'd5, 8'd1, 8'h22, 8'd1, 4'd3, 100, 60);

    m_ar_ready = 1'b1;
    start_run(1'b0, 16'h0200, 16'h0004, 16'd4, 8'd0, 8'h05, 8'd0, 4'd2);
    repeat (10) tick();
    chk("lim_reqcnt", reqCnt, 2);
    chk("lim_valid_low", m_ar_valid, 0);
    chk("lim_busy", busy, 1);
    beat(8'h05, 1'b1);
    chk("lim_valid_back", m_ar_valid, 1);
    chk("lim_addr3", m_ar_addr, 16'h0208);
    tick();
    chk("lim_req3", reqCnt, 3);
    beat(8'h05, 1'b1);
    tick();
    beat(8'h05, 1'b1);
    beat(8'h05, 1'b1);
    wait_done();
    chk("lim_final_req", reqCnt, 4);
    chk("lim_final_resp", respCnt, 4);
    chk("lim_final_err", errorCode, 0);

    m_ar_ready = 1'b0;
    start_run(1'b0, 16'h0001, 16'hFFFF, 16'd2, 8'd5, 8'h33, 8'd2, 4'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", m_ar_valid, 1);
      chk("bp_addr", m_ar_addr, 16'h0001);
      chk("bp_len", m_ar_len, 5);
      chk("bp_id", m_ar_id, 8'h33);
      chk("bp_reqcnt", reqCnt, 0);
      tick();
    end
    m_ar_ready = 1'b1;
    tick();
    chk("bp_req1", reqCnt, 1);
    chk("bp_wrap", m_ar_addr, 16'h0000);
    repeat (4) tick();
    chk("bp_req2", reqCnt, 2);
    burst(8'h33, 6);
    burst(8'h33, 6);
    wait_done();
    chk("bp_err", errorCode, 0);

    start_run(1'b0, 16'h0000, 16'h0001, 16'd2, 8'd3, 8'h10, 8'd0, 4'd8);
    repeat (3) tick();
    beat(8'h11, 1'b0);
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b1);
    chk("err_bad_id", errorCode, 3'b001);
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b1);
    chk("err_beats", errorCode, 3'b101);
    wait_done();
    chk("err_after_done", errorCode, 3'b101);
    beat(8'h10, 1'b1);
    chk("err_no_outst", errorCode, 3'b111);
    repeat (3) tick();
    chk("err_sticky", errorCode, 3'b111);

    start_run(1'b0, 16'h0040, 16'h0010, 16'd10, 8'd0, 8'h07, 8'd0, 4'd8);
    repeat (3) tick();
    chk("mid_reqcnt", reqCnt, 3);
    resetN = 1'b0;
    #1;
    chk("mid_rst_valid", m_ar_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_reqcnt", reqCnt, 0);
    chk("mid_rst_r_ready", m_r_ready, 0);
    chk("mid_rst_addr", m_ar_addr, 0);
    tick();
    resetN = 1'b1;
    tick();
    chk("mid_r_ready", m_r_ready, 1);
    run_cfg(1'b0, 16'h0500, 16'h0002, 16'd1, 8'd0, 8'h07, 8'd0, 4'd1, 100, 100);
    run_cfg(1'b0, 16'h0600, 16'h0001, 16'd0, 8'd0, 8'h07, 8'd0, 4'd1, 100, 100);

    for (int r = 0; r < 20; r++) begin
      int rp;
      if ($urandom_range(2) == 0) load(2'($urandom), 16'($urandom));
      rp = ($urandom_range(2) == 0) ? 100 : 30 + int'($urandom_range(60));
      run_cfg(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(12)),
              8'($urandom_range(3)), 8'($urandom), 8'($urandom_range(3)),
              4'($urandom_range(15)), rp, 30 + int'($urandom_range(70)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_ar_stream_gen.md
Name: axi_ar_stream_gen

Overview:
- Synthesizable AXI read-request generator; successor to the file-driven prefetcher stimulus.
- Issues AR bursts from one of two sources: a trace RAM loaded over a simple write port, or an arithmetic base+stride sequence.
- Enforces a configurable outstanding limit and an inter-request gap.
- Consumes R beats and reports counts and protocol errors.
- Sits in front of prefetcherTop's slave AR/R ports, in benches and FPGA bring-up.

Parameters:
- ADDR_BITS, 16, AR address width.
- TID_WIDTH, 8, AR/R ID width.
- BURST_LEN_WIDTH, 8, AR len width.
- LOG_TRACE_DEPTH, 6, trace RAM holds 2^LOG_TRACE_DEPTH addresses.
- LOG_MAX_OUTSTANDING, 3, hard cap on in-flight bursts is 2^LOG_MAX_OUTSTANDING.
- CNT_WIDTH, 16, request/response counter width.
- GAP_WIDTH, 8, inter-request gap counter width.

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous active-low reset.
- ld_valid  in  1  trace write strobe.
- ld_ready  out  1  trace write accepted; low while busy.
- ld_idx  in  LOG_TRACE_DEPTH  trace write index.
- ld_addr  in  ADDR_BITS  trace write address.
- start  in  1  single-cycle pulse; begins a run.
- cfg_mode  in  1  0=stride, 1=trace.
- cfg_base  in  ADDR_BITS  stride-mode start address.
- cfg_stride  in  ADDR_BITS  stride-mode increment.
- cfg_count  in  CNT_WIDTH  number of bursts in the run; 0 means an empty run.
- cfg_len  in  BURST_LEN_WIDTH  AR len for every burst.
- cfg_id  in  TID_WIDTH  AR ID for every burst.
- cfg_gap  in  GAP_WIDTH  idle cycles after each AR handshake.
- cfg_outLimit  in  LOG_MAX_OUTSTANDING+1  in-flight cap; clamped to 2^LOG_MAX_OUTSTANDING; 0 treated as 1.
- m_ar_valid  out  1  AR valid.
- m_ar_ready  in  1  AR ready.
- m_ar_addr  out  ADDR_BITS  AR address.
- m_ar_len  out  BURST_LEN_WIDTH  AR len.
- m_ar_id  out  TID_WIDTH  AR ID.
- m_r_valid  in  1  R valid.
- m_r_ready  out  1  R ready; always 1 except in reset.
- m_r_last  in  1  R last.
- m_r_id  in  TID_WIDTH  R ID.
- busy  out  1  run in progress.
- done  out  1  single-cycle pulse at run end.
- reqCnt  out  CNT_WIDTH  ARs issued this run.
- respCnt  out  CNT_WIDTH  bursts completed (r_last) this run.
- errorCode  out  3  sticky; bit0=R with unexpected ID, bit1=R while outstanding is 0, bit2=beat count differs from len+1.

Behaviour:
- Reset values: all outputs 0 (m_r_ready=0); state IDLE; counters 0; trace RAM contents undefined.
- m_r_ready goes to 1 on the first clk edge after reset is released.
- Configuration is sampled on start in IDLE and held for the whole run. start in any other state is ignored.
- IDLE:
  - ld_ready=1; a write occurs when ld_valid is high.
  - On start: clear reqCnt, respCnt and errorCode; set busy.
  - cfg_count==0 -> DONE; otherwise -> ISSUE.
- ISSUE:
  - m_ar_valid=1 only when outstanding < limit.
  - Address, len and ID are registered and stay stable while valid && !ready.
  - On handshake: reqCnt++ and outstanding++; advance the source.
  - Stride source: addr += stride, modulo 2^ADDR_BITS.
  - Trace source: idx++, wrapping at 2^LOG_TRACE_DEPTH, so counts larger than the depth replay the RAM.
  - Next state after a handshake: reqCnt==cfg_count -> DRAIN; else cfg_gap>0 -> GAP; else stay in ISSUE. Back-to-back ARs are allowed when the gap is 0.
- GAP: counts cfg_gap cycles with m_ar_valid=0, then -> ISSUE.
- DRAIN: when outstanding==0 -> DONE.
- DONE: done=1 for one cycle; busy=0; -> IDLE.
- R channel, every beat:
  - Beat counter increments.
  - On r_last: respCnt++ and outstanding--; compare the beat counter against cfg_len+1, then clear it.
  - An ID mismatch sets bit0 but the beat is still counted.
  - r_last arriving with outstanding==0 sets bit1 and leaves outstanding unchanged (no underflow).
- Simultaneous AR handshake and r_last in one cycle: outstanding is unchanged.
- Trace-mode read latency: the trace RAM read is synchronous, one cycle. The next address is prefetched during the handshake cycle, so no bubble is added.
- Reset asserted mid-run: everything returns to IDLE immediately and in-flight responses are forgotten; m_ar_valid drops asynchronously.

Optional Feature:
- Macro AXI_AR_STREAM_GEN_LAT_STATS_EN.
- Defined:
  - Adds outputs latMin and latMax, each CNT_WIDTH wide, measured in cycles from AR handshake to r_last.
  - Uses a timestamp FIFO of depth 2^LOG_MAX_OUTSTANDING, pushed on AR handshake and popped on r_last.
  - Both values clear on start; latMin resets to all-ones.
- Undefined: no ports, no FIFO, no counters.

Decomposition:
- Package axi_ar_stream_gen_pkg holds:
  - state_t enum {IDLE, ISSUE, GAP, DRAIN, DONE};
  - error bit index constants ERR_BAD_ID=0, ERR_NO_OUTST=1, ERR_BEATS=2;
  - mode constants MODE_STRIDE=0, MODE_TRACE=1.
- One sub-module, ar_stream_ts_fifo: a parametrised sync FIFO, instantiated only under the macro.
- The trace RAM is an inferred array in the top module.

Test Plan:
- Stride mode, base=0x0100, stride=3, count=4, len=0, gap=0, ready=1 -> ARs at 0x0100, 0x0103, 0x0106, 0x0109 on consecutive cycles; done after 4 r_last; errorCode=0.
- Trace mode: load idx0..2 = 0x0eef, 0x0ef2, 0x1000; count=5, LOG_TRACE_DEPTH=2 (RAM 0..3) -> addrs 0x0eef, 0x0ef2, 0x1000, RAM[3], 0x0eef.
- Outstanding limit: outLimit=2, memory never responds -> exactly 2 ARs, m_ar_valid low, busy held. Then one r_last -> a third AR in the next cycle.
- Backpressure: m_ar_ready low for 5 cycles during valid -> addr/len/id stable, reqCnt unchanged. Also: stride=0xFFFF from base 0x0001 wraps to 0x0000.
- Errors:
  - R with id=cfg_id+1 -> bit0 set.
  - r_last in IDLE -> bit1 set.
  - len=3 with only 2 beats before last -> bit2 set.
  - All bits stay sticky until the next start.
- Reset mid-run with 3 outstanding -> all outputs 0 on the next sample; a following start with count=1 completes normally.
